// File: rtl/synapse_accumulator.sv
// synapse_accumulator
//
// Front end of the neuron block. For one target neuron it walks a latched
// input spike vector, reads the synaptic weight of every spiking input from
// an external synchronous weight memory and sums those weights with
// saturation. A one-cycle done pulse marks the sum valid for the neuron.
//
// Ports:
//   clk                    clock, all state on the rising edge
//   reset_n                asynchronous active-low reset
//   start                  request a pass (accepted only in IDLE or DONE)
//   spikes_in              input spike vector, latched on acceptance
//   neuron_sel             target neuron, latched on acceptance
//   weight_addr            {latched neuron_sel, input index}
//   weight_rd_en           weight memory read strobe
//   weight_data            weight returned one cycle after weight_rd_en
//   potential_accumulated  saturated weight sum, sample with done
//   busy                   high while scanning or draining
//   done                   one-cycle result-valid pulse

module synapse_accumulator #(
  parameter int N_INPUTS = 8,
  parameter int IDX_W    = $clog2(N_INPUTS),
  parameter int NRN_W    = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [N_INPUTS-1:0]    spikes_in,
  input  logic [NRN_W-1:0]       neuron_sel,
  output logic [NRN_W+IDX_W-1:0] weight_addr,
  output logic                   weight_rd_en,
  input  logic [7:0]             weight_data,
  output logic [7:0]             potential_accumulated,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [IDX_W-1:0]      idx;
  logic [N_INPUTS-1:0]   spikes_lat;
  logic [NRN_W-1:0]      sel_lat;
  logic [7:0]            acc;
  logic                  pend;
  logic                  start_accept;
  logic                  last_idx;
  logic [8:0]            sum_wide;
  logic [7:0]            acc_sat;

  assign last_idx = (idx == IDX_W'(N_INPUTS - 1));

  // Next-state logic; a new pass can only be accepted from IDLE or DONE,
  // which is what makes back-to-back passes possible.
  always_comb begin
    state_next   = state;
    start_accept = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          state_next   = SCAN;
        end
      end
      SCAN: begin
        if (last_idx) state_next = DRAIN;
      end
      DRAIN: begin
        state_next = DONE;
      end
      DONE: begin
        if (start) begin
          start_accept = 1'b1;
          state_next   = SCAN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Read side is derived purely from registered state, so the memory sees
  // a clean address and strobe for the whole cycle.
  assign weight_addr  = {sel_lat, idx};
  assign weight_rd_en = (state == SCAN) && spikes_lat[idx];

  // Saturating add: any carry out of the 8-bit sum pins the result at 255,
  // and because weights are unsigned it stays there for the rest of the pass.
  always_comb begin
    sum_wide = {1'b0, acc} + {1'b0, weight_data};
    acc_sat  = sum_wide[8] ? 8'hFF : sum_wide[7:0];
  end

  // State, scan index, latched request and accumulator. pend remembers that
  // a read was issued last cycle so its data is absorbed on this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      spikes_lat <= '0;
      sel_lat    <= '0;
      acc        <= '0;
      pend       <= 1'b0;
    end else begin
      state <= state_next;
      pend  <= weight_rd_en;
      if (start_accept) begin
        spikes_lat <= spikes_in;
        sel_lat    <= neuron_sel;
        idx        <= '0;
        acc        <= '0;
      end else begin
        if (state == SCAN) idx <= idx + 1'b1;
        if (pend) acc <= acc_sat;
      end
    end
  end

  assign potential_accumulated = acc;
  assign busy                  = (state == SCAN) || (state == DRAIN);
  assign done                  = (state == DONE);

endmodule

// File: tb/tb_synapse_accumulator.sv
// tb_synapse_accumulator
//
// Bench for synapse_accumulator. Holds a weight memory model that answers one
// cycle after each read strobe (and returns junk otherwise), and a reference
// model that computes the expected saturated sum straight from the memory
// contents and the spike vector.

module tb_synapse_accumulator;

  localparam int N   = 8;
  localparam int IW  = 3;
  localparam int NW  = 4;
  localparam int AW  = NW + IW;
  localparam int LAT = N + 1;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [N-1:0]  spikes_in;
  logic [NW-1:0] neuron_sel;
  logic [AW-1:0] weight_addr;
  logic          weight_rd_en;
  logic [7:0]    weight_data;
  logic [7:0]    potential_accumulated;
  logic          busy;
  logic          done;

  logic [7:0]    mem [0:(1<<AW)-1];
  int            errors = 0;
  int            checks = 0;
  int            read_count = 0;
  int            bad_reads = 0;
  int            cyc = 0;
  int            done_cyc = 0;
  logic [AW-1:0] last_addr = '0;
  logic [N-1:0]  exp_spk = '0;
  logic [NW-1:0] exp_sel = '0;

  synapse_accumulator #(.N_INPUTS(N), .IDX_W(IW), .NRN_W(NW)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .start                 (start),
    .spikes_in             (spikes_in),
    .neuron_sel            (neuron_sel),
    .weight_addr           (weight_addr),
    .weight_rd_en          (weight_rd_en),
    .weight_data           (weight_data),
    .potential_accumulated (potential_accumulated),
    .busy                  (busy),
    .done                  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous weight memory; non-read cycles return junk so any stray
  // accumulation shows up in the result.
  always @(posedge clk) begin
    cyc++;
    if (weight_rd_en) weight_data <= mem[weight_addr];
    else              weight_data <= 8'($urandom);
  end

  // Read monitor: every read must target the selected neuron and a spiking input.
  always @(posedge clk) begin
    if (weight_rd_en) begin
      read_count++;
      last_addr = weight_addr;
      if (weight_addr[AW-1:IW] !== exp_sel || exp_spk[weight_addr[IW-1:0]] !== 1'b1)
        bad_reads++;
    end
  end

  // Reference: sum of the selected neuron's weights over spiking inputs,
  // clipped to 255.
  function automatic int ref_sum(input logic [N-1:0] spk, input logic [NW-1:0] sel);
    int s = 0;
    for (int i = 0; i < N; i++)
      if (spk[i]) s += int'(mem[{sel, IW'(i)}]);
    return (s > 255) ? 255 : s;
  endfunction

  function automatic int popcount(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pass. Unless prestarted, drives the request at a falling edge. Then
  // watches for done, checking busy, latency, read traffic and the result.
  // With chain set, start is raised again in the DONE cycle with the next
  // request; otherwise the result hold and absence of a second done are checked.
  task automatic apply_stimulus(input string tag, input logic [N-1:0] spk,
                                input logic [NW-1:0] sel, input bit prestarted,
                                input bit mid_start, input bit chain,
                                input logic [N-1:0] nxt_spk, input logic [NW-1:0] nxt_sel);
    int lat = -1;
    bit busy_ok = 1'b1;
    bit extra_done = 1'b0;
    bit hold_ok = 1'b1;
    int expv = ref_sum(spk, sel);
    if (!prestarted) begin
      @(negedge clk);
      spikes_in  = spk;
      neuron_sel = sel;
      start      = 1'b1;
    end
    exp_spk    = spk;
    exp_sel    = sel;
    read_count = 0;
    bad_reads  = 0;
    @(posedge clk);
    #1;
    start      = 1'b0;
    spikes_in  = N'($urandom);
    neuron_sel = NW'($urandom);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done) begin
        lat      = n;
        done_cyc = cyc;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (mid_start && n == 3) begin
        start     = 1'b1;
        spikes_in = ~spk;
      end
      if (mid_start && n == 4) start = 1'b0;
    end
    check_output({tag, "_latency"}, lat, LAT);
    check_output({tag, "_busy"}, busy_ok, 1'b1);
    check_output({tag, "_result"}, potential_accumulated, expv);
    check_output({tag, "_reads"}, read_count, popcount(spk));
    check_output({tag, "_bad_reads"}, bad_reads, 0);
    if (chain) begin
      spikes_in  = nxt_spk;
      neuron_sel = nxt_sel;
      start      = 1'b1;
    end else begin
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (done) extra_done = 1'b1;
        if (potential_accumulated !== 8'(expv)) hold_ok = 1'b0;
      end
      check_output({tag, "_single_done"}, extra_done, 1'b0);
      check_output({tag, "_hold"}, hold_ok, 1'b1);
    end
  endtask

  initial begin
    int first_done;
    bit seen_done;
    logic [N-1:0]  rs;
    logic [NW-1:0] rn;

    for (int a = 0; a < (1 << AW); a++) mem[a] = 8'($urandom);
    mem[{4'd3, 3'd3}] = 8'h20;
    for (int i = 0; i < N; i++) begin
      mem[{4'd5, IW'(i)}] = 8'd40;
      mem[{4'd6, IW'(i)}] = (i == 0) ? 8'd31 : 8'd32;
      mem[{4'd7, IW'(i)}] = (i == 0) ? 8'd30 : 8'd32;
    end

    reset_n    = 1'b0;
    start      = 1'b0;
    spikes_in  = '0;
    neuron_sel = '0;
    #23;
    check_output("reset_addr", weight_addr, 0);
    check_output("reset_rd_en", weight_rd_en, 0);
    check_output("reset_pot", potential_accumulated, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] directed passes");
    apply_stimulus("zero", 8'h00, 4'd2, 0, 0, 0, '0, '0);
    apply_stimulus("single", 8'h08, 4'd3, 0, 0, 0, '0, '0);
    check_output("single_addr", last_addr, {4'd3, 3'd3});
    apply_stimulus("sat320", 8'hFF, 4'd5, 0, 0, 0, '0, '0);
    check_output("sat320_value", potential_accumulated, 255);
    apply_stimulus("sum255", 8'hFF, 4'd6, 0, 0, 0, '0, '0);
    apply_stimulus("sum254", 8'hFF, 4'd7, 0, 0, 0, '0, '0);
    check_output("sum254_value", potential_accumulated, 254);
    apply_stimulus("midstart", 8'hA5, 4'd9, 0, 1, 0, '0, '0);

    $display("[TB] reset during scan");
    @(negedge clk);
    spikes_in  = 8'hFF;
    neuron_sel = 4'd4;
    start      = 1'b1;
    exp_spk    = 8'hFF;
    exp_sel    = 4'd4;
    read_count = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (read_count >= 3) break;
    end
    check_output("abort_reads_seen", read_count, 3);
    reset_n = 1'b0;
    #1;
    check_output("abort_outputs", {weight_addr, weight_rd_en, potential_accumulated, busy, done}, 0);
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check_output("abort_no_done", seen_done, 0);
    apply_stimulus("after_abort", 8'h3C, 4'd4, 0, 0, 0, '0, '0);

    $display("[TB] back-to-back");
    apply_stimulus("b2b_first", 8'hFF, 4'd5, 0, 0, 1, 8'h11, 4'd1);
    first_done = done_cyc;
    apply_stimulus("b2b_second", 8'h11, 4'd1, 1, 0, 0, '0, '0);
    check_output("b2b_spacing", done_cyc - first_done, N + 2);

    $display("[TB] random passes");
    for (int r = 0; r < 6; r++) begin
      rs = N'($urandom);
      rn = NW'($urandom);
      apply_stimulus($sformatf("rand%0d", r), rs, rn, 0, 0, 0, '0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
